// File: rtl/vanilla_scoreboard_tracker_pkg.sv
// rtl/vanilla_scoreboard_tracker_pkg.sv - shared class indices and sizing helper for the outstanding tracker
package vanilla_scoreboard_tracker_pkg;

    // Scoreboard class indices; the amo classes exist only when num_class_p > 4.
    typedef enum logic [2:0] {
        e_sb_long_op       = 3'd0,
        e_sb_remote_dram   = 3'd1,
        e_sb_remote_global = 3'd2,
        e_sb_remote_group  = 3'd3,
        e_sb_amo_dram      = 3'd4,
        e_sb_amo_global    = 3'd5
    } sb_class_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/vanilla_outstanding_entry.sv
// rtl/vanilla_outstanding_entry.sv - per-register outstanding counters, age counter and timeout bit
module vanilla_outstanding_entry
    import vanilla_scoreboard_tracker_pkg::*;
#(
    parameter int num_class_p   = 4,
    parameter int count_width_p = 2,
    parameter int timeout_p     = 4096,
    parameter int age_width_p   = safe_clog2(timeout_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [num_class_p-1:0] set_hit_i,
    input  logic [num_class_p-1:0] clear_hit_i,
    output logic [num_class_p-1:0] pending_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam logic [count_width_p-1:0] cnt_max_lp = '1;
    localparam logic [age_width_p-1:0]   age_max_lp = age_width_p'(timeout_p);

    logic [num_class_p-1:0][count_width_p-1:0] count_q, count_d;
    logic [age_width_p-1:0]                    age_q, age_d;
    logic                                      timeout_q, timeout_d;
    logic                                      busy_next;

    // A set and a clear on the same class cancel, so a saturated or empty
    // counter is never flagged in that case.
    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        for (int c = 0; c < num_class_p; c++) begin
            if (set_hit_i[c] && !clear_hit_i[c]) begin
                if (count_q[c] == cnt_max_lp) begin
                    ovf_o = 1'b1;
                end else begin
                    count_d[c] = count_q[c] + 1'b1;
                end
            end else if (clear_hit_i[c] && !set_hit_i[c]) begin
                if (count_q[c] == '0) begin
                    unf_o = 1'b1;
                end else begin
                    count_d[c] = count_q[c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int c = 0; c < num_class_p; c++) begin
            pending_o[c] = (count_q[c] != '0);
        end
    end

    assign busy_o    = |pending_o;
    assign timeout_o = timeout_q;

    // Age counts edges spent busy, so it starts from the edge after the first set.
    always_comb begin
        busy_next = 1'b0;
        for (int c = 0; c < num_class_p; c++) begin
            busy_next = busy_next | (count_d[c] != '0);
        end
        age_d = age_q;
        if (!busy_next || (|clear_hit_i)) begin
            age_d = '0;
        end else if (busy_o && (age_q != age_max_lp)) begin
            age_d = age_q + 1'b1;
        end
        timeout_d = busy_next && (timeout_q || (age_d == age_max_lp));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q   <= '0;
            age_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            age_q     <= age_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/vanilla_outstanding_tracker.sv
// rtl/vanilla_outstanding_tracker.sv - per-register, per-class outstanding writeback tracker with aging
module vanilla_outstanding_tracker
    import vanilla_scoreboard_tracker_pkg::*;
#(
    parameter int reg_els_p        = 32,
    parameter int reg_addr_width_p = safe_clog2(reg_els_p),
    parameter int num_class_p      = 4,
    parameter int class_width_p    = safe_clog2(num_class_p),
    parameter int count_width_p    = 2,
    parameter int timeout_p        = 4096,
    parameter int ignore_zero_p    = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             set_v_i,
    input  logic [reg_addr_width_p-1:0]      set_id_i,
    input  logic [class_width_p-1:0]         set_class_i,
    input  logic                             clear_v_i,
    input  logic [reg_addr_width_p-1:0]      clear_id_i,
    input  logic [class_width_p-1:0]         clear_class_i,
    output logic [reg_els_p*num_class_p-1:0] pending_o,
    output logic [reg_els_p-1:0]             busy_o,
    output logic [reg_els_p-1:0]             timeout_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam logic [reg_addr_width_p:0] reg_els_lp   = (reg_addr_width_p + 1)'(reg_els_p);
    localparam logic [class_width_p:0]    num_class_lp = (class_width_p + 1)'(num_class_p);

    logic                   set_ok, clear_ok;
    logic [num_class_p-1:0] set_cls_oh, clear_cls_oh;
    logic [reg_els_p-1:0]   ovf_vec, unf_vec;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    // Register 0 sets are dropped outright, but clears to it still count.
    always_comb begin
        set_ok = set_v_i
              && ({1'b0, set_id_i} < reg_els_lp)
              && ({1'b0, set_class_i} < num_class_lp)
              && !((ignore_zero_p != 0) && (set_id_i == '0));
        clear_ok = clear_v_i
                && ({1'b0, clear_id_i} < reg_els_lp)
                && ({1'b0, clear_class_i} < num_class_lp);
        set_cls_oh   = set_ok   ? (num_class_p'(1) << set_class_i)   : '0;
        clear_cls_oh = clear_ok ? (num_class_p'(1) << clear_class_i) : '0;
    end

    for (genvar r = 0; r < reg_els_p; r++) begin : g_entry
        logic [num_class_p-1:0] set_hit, clear_hit;

        assign set_hit   = (set_id_i   == reg_addr_width_p'(r)) ? set_cls_oh   : '0;
        assign clear_hit = (clear_id_i == reg_addr_width_p'(r)) ? clear_cls_oh : '0;

        vanilla_outstanding_entry #(
            .num_class_p   (num_class_p),
            .count_width_p (count_width_p),
            .timeout_p     (timeout_p)
        ) u_entry (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .set_hit_i   (set_hit),
            .clear_hit_i (clear_hit),
            .pending_o   (pending_o[r*num_class_p +: num_class_p]),
            .busy_o      (busy_o[r]),
            .timeout_o   (timeout_o[r]),
            .ovf_o       (ovf_vec[r]),
            .unf_o       (unf_vec[r])
        );
    end

    always_comb begin
        overflow_d  = overflow_q  | (|ovf_vec);
        underflow_d = underflow_q | (|unf_vec);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vanilla_outstanding_tracker.sv
// tb/tb_vanilla_outstanding_tracker.sv - directed and randomized checks of the outstanding tracker
module tb_vanilla_outstanding_tracker;

    localparam int REGS = 32;
    localparam int CLS  = 4;
    localparam int MAXC = 3;
    localparam int TMO  = 8;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         set_v_i = 1'b0;
    logic [4:0]   set_id_i = '0;
    logic [1:0]   set_class_i = '0;
    logic         clear_v_i = 1'b0;
    logic [4:0]   clear_id_i = '0;
    logic [1:0]   clear_class_i = '0;
    logic [127:0] pending_o;
    logic [31:0]  busy_o;
    logic [31:0]  timeout_o;
    logic         overflow_o;
    logic         underflow_o;

    int tests = 0;
    int fails = 0;

    int cnt [REGS][CLS];
    int age [REGS];
    bit tmo [REGS];
    bit m_ovf, m_unf;

    vanilla_outstanding_tracker #(
        .reg_els_p     (32),
        .num_class_p   (4),
        .count_width_p (2),
        .timeout_p     (TMO),
        .ignore_zero_p (1)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .set_v_i       (set_v_i),
        .set_id_i      (set_id_i),
        .set_class_i   (set_class_i),
        .clear_v_i     (clear_v_i),
        .clear_id_i    (clear_id_i),
        .clear_class_i (clear_class_i),
        .pending_o     (pending_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit reg_busy(input int r);
        for (int c = 0; c < CLS; c++) if (cnt[r][c] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Model: one call per clock edge, applying the event rules directly.
    task automatic model_step(input bit sv, input int sid, input int scls,
                              input bit cv, input int cid, input int ccls, input bit rst);
        bit busy_old [REGS];
        bit s_ok, c_ok, bn;
        if (rst) begin
            for (int r = 0; r < REGS; r++) begin
                for (int c = 0; c < CLS; c++) cnt[r][c] = 0;
                age[r] = 0;
                tmo[r] = 1'b0;
            end
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        for (int r = 0; r < REGS; r++) busy_old[r] = reg_busy(r);
        s_ok = sv && sid < REGS && scls < CLS && sid != 0;
        c_ok = cv && cid < REGS && ccls < CLS;
        if (!(s_ok && c_ok && sid == cid && scls == ccls)) begin
            if (s_ok) begin
                if (cnt[sid][scls] == MAXC) m_ovf = 1'b1;
                else cnt[sid][scls]++;
            end
            if (c_ok) begin
                if (cnt[cid][ccls] == 0) m_unf = 1'b1;
                else cnt[cid][ccls]--;
            end
        end
        for (int r = 0; r < REGS; r++) begin
            bn = reg_busy(r);
            if (!bn || (c_ok && cid == r)) age[r] = 0;
            else if (busy_old[r] && age[r] < TMO) age[r]++;
            tmo[r] = bn && (tmo[r] || age[r] == TMO);
        end
    endtask

    task automatic check_all();
        logic [127:0] ep;
        logic [31:0]  eb, et;
        ep = '0;
        eb = '0;
        et = '0;
        for (int r = 0; r < REGS; r++) begin
            for (int c = 0; c < CLS; c++) ep[r*CLS+c] = (cnt[r][c] != 0);
            eb[r] = reg_busy(r);
            et[r] = tmo[r];
        end
        chk("pending", pending_o, ep);
        chk("busy", busy_o, eb);
        chk("timeout", timeout_o, et);
        chk("overflow", overflow_o, m_ovf);
        chk("underflow", underflow_o, m_unf);
    endtask

    task automatic step(input bit sv, input int sid, input int scls,
                        input bit cv, input int cid, input int ccls, input bit rst);
        set_v_i       = sv;
        set_id_i      = 5'(sid);
        set_class_i   = 2'(scls);
        clear_v_i     = cv;
        clear_id_i    = 5'(cid);
        clear_class_i = 2'(ccls);
        reset_i       = rst;
        @(posedge clk_i);
        model_step(sv, sid, scls, cv, cid, ccls, rst);
        @(negedge clk_i);
        set_v_i   = 1'b0;
        clear_v_i = 1'b0;
        reset_i   = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_set(input int r, input int c);
        step(1, r, c, 0, 0, 0, 0);
    endtask

    task automatic do_clr(input int r, input int c);
        step(0, 0, 0, 1, r, c, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();
        chk("reset_pending", pending_o, 128'd0);
        chk("reset_flags", {overflow_o, underflow_o}, 2'b00);

        // multiple outstanding on (5,1)
        do_set(5, 1); do_set(5, 1); do_set(5, 1);
        chk("multi_p21_set", pending_o[21], 1'b1);
        do_clr(5, 1); do_clr(5, 1);
        chk("multi_p21_hold", pending_o[21], 1'b1);
        chk("multi_busy5_hold", busy_o[5], 1'b1);
        do_clr(5, 1);
        chk("multi_p21_drop", pending_o[21], 1'b0);
        chk("multi_busy5_drop", busy_o[5], 1'b0);

        // simultaneous set and clear
        do_set(7, 2);
        step(1, 7, 2, 1, 7, 2, 0);
        chk("sc_same_p30", pending_o[30], 1'b1);
        chk("sc_same_flags", {overflow_o, underflow_o}, 2'b00);
        do_clr(7, 2);
        do_set(4, 0);
        step(1, 3, 0, 1, 4, 0, 0);
        chk("sc_diff_p12", pending_o[12], 1'b1);
        chk("sc_diff_p16", pending_o[16], 1'b0);
        do_clr(3, 0);

        // timeout without intervening clear
        do_reset();
        do_set(12, 1);
        idle(7);
        chk("tmo_edge7", timeout_o[12], 1'b0);
        idle(1);
        chk("tmo_edge8", timeout_o[12], 1'b1);
        do_clr(12, 1);
        chk("tmo_cleared", timeout_o[12], 1'b0);

        // a partial clear restarts the age
        do_set(12, 1);
        do_set(12, 2);
        idle(4);
        do_clr(12, 2);
        chk("tmo_partial_busy", busy_o[12], 1'b1);
        idle(7);
        chk("tmo_edge13", timeout_o[12], 1'b0);
        idle(1);
        chk("tmo_edge14", timeout_o[12], 1'b1);
        do_clr(12, 1);
        chk("tmo_edge14_clear", timeout_o[12], 1'b0);

        // saturation and underflow
        do_reset();
        do_set(9, 3); do_set(9, 3); do_set(9, 3);
        chk("sat_no_ovf", overflow_o, 1'b0);
        do_set(9, 3);
        chk("sat_ovf", overflow_o, 1'b1);
        chk("sat_p39", pending_o[39], 1'b1);
        do_clr(10, 0);
        chk("unf_flag", underflow_o, 1'b1);
        chk("unf_p40", pending_o[40], 1'b0);
        idle(3);
        chk("flags_sticky", {overflow_o, underflow_o}, 2'b11);
        do_clr(9, 3); do_clr(9, 3);
        chk("sat_count3_p39", pending_o[39], 1'b1);
        do_clr(9, 3);
        chk("sat_count3_drop", pending_o[39], 1'b0);

        // register zero
        do_reset();
        do_set(0, 0);
        chk("zero_p0", pending_o[0], 1'b0);
        chk("zero_no_flag", {overflow_o, underflow_o}, 2'b00);
        do_clr(0, 0);
        chk("zero_unf", underflow_o, 1'b1);

        // reset mid-operation drops a concurrent set
        do_reset();
        do_set(2, 0);
        do_set(30, 1);
        idle(8);
        chk("mid_tmo30", timeout_o[30], 1'b1);
        step(1, 5, 0, 0, 0, 0, 1);
        chk("mid_pending", pending_o, 128'd0);
        chk("mid_timeout", timeout_o, 128'd0);
        chk("mid_busy", busy_o, 128'd0);
        idle(1);
        chk("mid_set_dropped", pending_o[20], 1'b0);

        // randomized traffic on a narrow id range to force collisions
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit sv, cv, rst;
            int sid, cid;
            sv  = ($urandom_range(0, 99) < 55);
            cv  = ($urandom_range(0, 99) < 45);
            rst = ($urandom_range(0, 127) == 0);
            sid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            cid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            step(sv, sid, int'($urandom_range(0, 3)), cv, cid, int'($urandom_range(0, 3)), rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vanilla_outstanding_tracker.md
# vanilla_outstanding_tracker

Parametrised scoreboard tracker for the vanilla core testbench. It counts outstanding long-latency writebacks per architectural register and per class: multiple in-flight requests per register, not a single bit. It ages every busy register and raises a sticky timeout once a writeback has been pending too long, and flags set/clear protocol violations. One instance sits beside each register file (int, float) in the core profiler/trace harness, and is driven by already-qualified issue (set) and writeback (clear) events.

## Interface
Parameters:
- `reg_els_p`, 32: registers tracked.
- `reg_addr_width_p`, `` `BSG_SAFE_CLOG2(reg_els_p) ``: register id width.
- `num_class_p`, 4: scoreboard classes (idiv/fdiv, dram load, global load, group load, ...).
- `class_width_p`, `` `BSG_SAFE_CLOG2(num_class_p) ``: class index width.
- `count_width_p`, 2: per-(reg,class) counter width; max outstanding = 2^count_width_p - 1.
- `timeout_p`, 4096: cycles a register may remain busy before timeout; must be ≥1.
- `ignore_zero_p`, 1: if 1, sets to register 0 are dropped (x0).

Ports:
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: reset; synchronous, active-high.
- `set_v_i`, in, 1: issue event; caller has already gated it with stall and flush.
- `set_id_i`, in, reg_addr_width_p: destination register.
- `set_class_i`, in, class_width_p: class of the issued op.
- `clear_v_i`, in, 1: writeback event.
- `clear_id_i`, in, reg_addr_width_p: register written back.
- `clear_class_i`, in, class_width_p: class retired.
- `pending_o`, out, reg_els_p*num_class_p: bit [r*num_class_p+c] = count(r,c)≠0.
- `busy_o`, out, reg_els_p: OR over classes of `pending_o` per register.
- `timeout_o`, out, reg_els_p: sticky per-register timeout.
- `overflow_o`, out, 1: sticky; a set hit a saturated counter.
- `underflow_o`, out, 1: sticky; a clear hit a zero counter.

## Operation
- Counter update per (r,c) each cycle:
  - set only (match r,c): count+1.
  - clear only: count-1.
  - both: unchanged.
  - Set and clear on different entries update independently.
- Saturation:
  - A set with count = max leaves count at max and sets `overflow_o`. A set+clear to a max entry is legal and does not flag.
  - A clear alone with count = 0 leaves count at 0 and sets `underflow_o`.
- `ignore_zero_p`=1: a set with `set_id_i`=0 is ignored entirely, and no flag is raised. A clear to register 0 is processed normally, so it underflows.
- Out-of-range ids (≥ reg_els_p) or classes (≥ num_class_p) are ignored.
- Age counter per register, width `` `BSG_SAFE_CLOG2(timeout_p+1) ``:
  - Reset to 0 when register r is not busy next cycle, or on any accepted clear to r.
  - Otherwise increments while r is busy, saturating at `timeout_p`.
- Timeout: when age(r) reaches `timeout_p`, `timeout_o[r]` sets. It clears only when r becomes not busy or on reset; a clear to r that leaves r still busy restarts the age but does not drop `timeout_o[r]`.
- Overflow/underflow flags clear only on reset.

## Timing
- All outputs are registered. An event at edge t appears on `pending_o`/`busy_o` after edge t, so it is visible in cycle t+1.
- Timeout:
  - A set accepted at edge t with no further events gives age = k after edge t+k.
  - `timeout_o` rises in the cycle after the edge where age reaches `timeout_p`, i.e. `timeout_p` edges after the set.
- Reset: all counters, ages and flags are 0; every output is 0 in the cycle after reset is sampled. Reset dominates any concurrent set/clear, and events during reset are lost.
- No backpressure: every event is consumed in its cycle.

## Structure
- Class index constants go in `vanilla_scoreboard_tracker_pkg`: `e_sb_long_op`=0, `e_sb_remote_dram`=1, `e_sb_remote_global`=2, `e_sb_remote_group`=3, plus `e_sb_amo_*` when num_class_p>4.
- Sub-module `vanilla_outstanding_entry` holds one register's num_class_p counters, age counter and timeout bit. It takes decoded `set_hit`/`clear_hit` one-hot class vectors and returns pending, busy, timeout, ovf and unf.
- The top decodes ids, generates reg_els_p entries and OR-reduces the per-entry ovf/unf into the sticky flags.

## Test plan
- Multi-outstanding: set (5,1) three times, then clear (5,1) three times → `pending_o[21]`=1 until the cycle after the third clear; `busy_o[5]` falls at the same time.
- Simultaneous set+clear of (7,2) with count=1 → count stays 1, no flags. Separately, set (3,0) + clear (4,0) with count(4,0)=1 → (3,0) pending, (4,0) idle.
- Saturation (count_width_p=2): four sets to (9,3) → count 3, `overflow_o`=1. A later clear to (10,0) at 0 → `underflow_o`=1, count stays 0. Both flags hold until reset.
- Timeout (timeout_p=8):
  - Set (12,1) with no clear → `timeout_o[12]` rises 8 edges after the set.
  - A clear of another class on r12 at edge 6, with r12 still busy, delays the timeout to edge 14.
  - A full clear drops `timeout_o[12]` next cycle.
- Zero register with ignore_zero_p=1: set (0,0) → no pending, no flag. Clear (0,0) → `underflow_o`=1.
- Reset mid-operation: with r2/r30 pending and `timeout_o[30]`=1, assert reset alongside a set → all outputs 0 the next cycle and the set is dropped.
